bcd_updown_counter_n: RTL and testbench
=======================================

Name: bcd_updown_counter_n

Overview:
Parametrised N-digit BCD up/down counter, the successor to the two-digit fixed-limit lab counter. It adds a runtime-programmable upper limit, synchronous load, and wrap or bounce (ping-pong) limit handling. It also adds a synchronous run/pause toggle driven from a pushbutton level and terminal max/min/cout flags. It sits between debounced board inputs and the seven-segment display driver.

Parameters:
DIGITS, 2, number of BCD digits; count width is 4*DIGITS.
RESET_RUN, 1, value of the running flag after reset (1 = counting).

Ports:
clk  input  1  system clock; all state changes on posedge clk.
reset  input  1  synchronous active-low reset, sampled on posedge clk.
en_btn  input  1  debounced pushbutton level; each falling edge toggles running.
tick  input  1  count strobe; one step per clk cycle with tick=1.
dir  input  1  requested direction, 1 = up, 0 = down.
bounce  input  1  1 = reverse direction at the limits, 0 = wrap around.
limit  input  4*DIGITS  upper limit in BCD; min is always 0.
load  input  1  synchronous load strobe.
load_val  input  4*DIGITS  BCD value to load.
bcd  output  4*DIGITS  current count; digit 0 in bits [3:0].
running  output  1  1 = counting enabled.
dir_eff  output  1  effective direction register.
max  output  1  combinational: bcd == limit.
min  output  1  combinational: bcd == 0.
cout  output  1  registered one-cycle pulse on a wrap or turnaround.

Behaviour:
- Reset (reset==0 at posedge clk):
  - bcd=0, running=RESET_RUN, dir_eff=1, cout=0, en_btn edge register=0.
  - Hence min=1; max=1 only if limit==0.
- Run toggle:
  - en_q <= en_btn every cycle.
  - Falling edge (en_q==1 && en_btn==0) toggles running.
  - One toggle per edge; a held level has no effect.
- Priority each cycle: reset > load > step > hold.
- Load:
  - Honoured regardless of running or tick.
  - bcd <= load_val if every digit ≤9 and load_val ≤ limit; otherwise bcd <= limit.
  - cout=0. dir_eff unchanged.
- Step: occurs when running && tick && !load. cout defaults to 0 on every non-step cycle.
- Direction:
  - When bounce=0, dir_eff <= dir every cycle; the step uses the dir input directly.
  - When bounce=1, dir_eff is owned by the counter; dir is ignored except on the cycle bounce rises, when dir_eff <= dir.
- Step, wrap mode (bounce=0):
  - Up, bcd<limit: BCD increment.
  - Up, bcd==limit: bcd<=0, cout=1.
  - Down, bcd>0: BCD decrement.
  - Down, bcd==0: bcd<=limit, cout=1.
- Step, bounce mode (bounce=1):
  - Up, bcd==limit: bcd<=limit-1, dir_eff<=0, cout=1.
  - Down, bcd==0: bcd<=1, dir_eff<=1, cout=1.
  - Otherwise normal increment/decrement in the dir_eff direction.
- Limit edge cases:
  - limit==0: every step holds bcd=0, cout=0, dir_eff unchanged.
  - limit lowered below the current bcd: the next step sets bcd<=limit, cout=0, either direction and either mode.
- Arithmetic:
  - Per-digit ripple. Increment: digit 9→0 with carry to the next digit.
  - Decrement: digit 0→9 with borrow.
  - Top-digit carry/borrow is never reached because limit checks precede it.
  - Invalid digits never appear in bcd.
- Latency: bcd updates one clk after the qualifying edge. max/min follow bcd combinationally. cout is aligned with the new bcd value.
- Reset mid-count overrides load/step in the same cycle.

Decomposition:
- Shared package/header bcd_defs:
  - constant BCD_W=4, BCD_MAX_DIGIT=4'd9;
  - direction constants DIR_UP=1, DIR_DN=0;
  - function bcd_valid(digit).
- Sub-module bcd_digit: one digit, inputs digit/inc/dec/cin, outputs next digit and carry/borrow out.
- Instantiated DIGITS times in a generate loop; the top holds the limit compare, mode logic, toggle and registers.

Test Plan:
- DIGITS=2, limit=8'h59, bounce=0, dir=1, tick=1 every cycle from reset:
  - bcd runs 00..59, then 00; cout high exactly on the 59→00 cycle.
  - max high at 59; min high at 00.
- Same setup with bounce=1:
  - sequence 58, 59, 58 with cout on the 59→58 step and dir_eff 1→0;
  - descent to 00, then 01 with dir_eff back to 1.
- limit=8'h89, dir=0 from 00 in wrap mode: next bcd=89, cout=1. Then 88, 87.
- en_btn pulses 1→0 twice, 10 cycles apart, tick=1:
  - running goes 1→0 (bcd frozen), then 0→1 (resumes);
  - holding en_btn=0 causes no extra toggle.
- Loads at limit=8'h59:
  - load_val=8'h42 → bcd=42;
  - load_val=8'h7A (invalid digit) → bcd=59;
  - load together with tick → load wins.
- bcd=45, limit changed to 8'h30, one tick → bcd=30, cout=0.
- reset=0 asserted during counting → next edge bcd=00, running=1, dir_eff=1.

Source files
------------

// File: rtl/bcd_defs.sv
// Shared BCD constants and helpers for the BCD counter family.
package bcd_defs;

  localparam int            BCD_W         = 4;
  localparam logic [3:0]    BCD_MAX_DIGIT = 4'd9;
  localparam logic          DIR_UP        = 1'b1;
  localparam logic          DIR_DN        = 1'b0;

  function automatic logic bcd_valid(input logic [BCD_W-1:0] digit);
    return digit <= BCD_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of a ripple increment/decrement chain.
module bcd_digit
  import bcd_defs::*;
(
  input  logic [BCD_W-1:0] digit,
  input  logic             inc,
  input  logic             dec,
  input  logic             cin,
  output logic [BCD_W-1:0] nxt,
  output logic             cout
);

  // cin means "this digit moves"; cout is carry when incrementing, borrow when decrementing
  always_comb begin
    nxt  = digit;
    cout = 1'b0;
    if (cin) begin
      if (inc) begin
        if (digit >= BCD_MAX_DIGIT) begin
          nxt  = '0;
          cout = 1'b1;
        end else begin
          nxt = digit + 4'd1;
        end
      end else if (dec) begin
        if (digit == '0) begin
          nxt  = BCD_MAX_DIGIT;
          cout = 1'b1;
        end else begin
          nxt = digit - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_updown_counter_n.sv
// N-digit BCD up/down counter with programmable limit, load, wrap/bounce
// handling and a pushbutton run/pause toggle.
module bcd_updown_counter_n
  import bcd_defs::*;
#(
  parameter int DIGITS    = 2,
  parameter bit RESET_RUN = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en_btn,
  input  logic                  tick,
  input  logic                  dir,
  input  logic                  bounce,
  input  logic [4*DIGITS-1:0]   limit,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  running,
  output logic                  dir_eff,
  output logic                  max,
  output logic                  min,
  output logic                  cout
);

  localparam int W = BCD_W * DIGITS;

  logic [W-1:0]    inc_val, dec_val, bcd_nxt;
  logic [DIGITS:0] inc_c, dec_c;
  logic            en_q, bounce_q, bounce_rise, step_dir;
  logic            dir_nxt, cout_nxt, load_ok;
  logic            unused_carry;

  assign inc_c[0] = 1'b1;
  assign dec_c[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_inc (
      .digit (bcd[g*BCD_W +: BCD_W]),
      .inc   (1'b1),
      .dec   (1'b0),
      .cin   (inc_c[g]),
      .nxt   (inc_val[g*BCD_W +: BCD_W]),
      .cout  (inc_c[g+1])
    );
    bcd_digit u_dec (
      .digit (bcd[g*BCD_W +: BCD_W]),
      .inc   (1'b0),
      .dec   (1'b1),
      .cin   (dec_c[g]),
      .nxt   (dec_val[g*BCD_W +: BCD_W]),
      .cout  (dec_c[g+1])
    );
  end

  // Limit checks always act before the top digit could carry or borrow out
  assign unused_carry = inc_c[DIGITS] ^ dec_c[DIGITS];

  assign max = (bcd == limit);
  assign min = (bcd == '0);

  always_comb begin
    load_ok = (load_val <= limit);
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_valid(load_val[i*BCD_W +: BCD_W])) load_ok = 1'b0;
    end

    bounce_rise = bounce && !bounce_q;
    step_dir    = bounce ? (bounce_rise ? dir : dir_eff) : dir;
    dir_nxt     = step_dir;
    bcd_nxt     = bcd;
    cout_nxt    = 1'b0;

    if (load) begin
      bcd_nxt = load_ok ? load_val : limit;
    end else if (running && tick) begin
      if (limit == '0) begin
        bcd_nxt = '0;
      end else if (bcd > limit) begin
        bcd_nxt = limit;
      end else if (step_dir == DIR_UP) begin
        if (bcd == limit) begin
          cout_nxt = 1'b1;
          if (bounce) begin
            bcd_nxt = dec_val;
            dir_nxt = DIR_DN;
          end else begin
            bcd_nxt = '0;
          end
        end else begin
          bcd_nxt = inc_val;
        end
      end else begin
        if (bcd == '0) begin
          cout_nxt = 1'b1;
          if (bounce) begin
            bcd_nxt = inc_val;
            dir_nxt = DIR_UP;
          end else begin
            bcd_nxt = limit;
          end
        end else begin
          bcd_nxt = dec_val;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bcd      <= '0;
      running  <= RESET_RUN;
      dir_eff  <= DIR_UP;
      cout     <= 1'b0;
      en_q     <= 1'b0;
      bounce_q <= 1'b0;
    end else begin
      en_q     <= en_btn;
      bounce_q <= bounce;
      if (en_q && !en_btn) running <= !running;
      bcd      <= bcd_nxt;
      dir_eff  <= dir_nxt;
      cout     <= cout_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Scoreboard bench for the 2-digit BCD up/down counter.
module tb_bcd_updown_counter_n;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en_btn = 1'b0;
  logic       tick = 1'b0;
  logic       dir = 1'b1;
  logic       bounce = 1'b0;
  logic       load = 1'b0;
  logic [7:0] limit = 8'h59;
  logic [7:0] load_val = 8'h00;
  logic [7:0] bcd;
  logic       running, dir_eff, max, min, cout;

  typedef struct {
    logic [7:0] bcd;
    logic       cout;
    logic       run;
    logic       dir;
    logic       mx;
    logic       mn;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  int    checks = 0;
  int    errors = 0;
  exp_t  me;
  string mname;

  bcd_updown_counter_n #(.DIGITS(2), .RESET_RUN(1'b1)) dut (
    .clk      (clk),
    .reset    (reset),
    .en_btn   (en_btn),
    .tick     (tick),
    .dir      (dir),
    .bounce   (bounce),
    .limit    (limit),
    .load     (load),
    .load_val (load_val),
    .bcd      (bcd),
    .running  (running),
    .dir_eff  (dir_eff),
    .max      (max),
    .min      (min),
    .cout     (cout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] b2b(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  task automatic chk(input string nm, input string fld, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s.%s got=%h want=%h at %0t", nm, fld, act, expv, $time);
    end
  endtask

  // push the state expected after the coming edge, then let the edge happen
  task automatic step(input string nm, input logic [7:0] e_bcd, input logic e_cout,
                      input logic e_run, input logic e_dir);
    exp_t e;
    e.bcd  = e_bcd;
    e.cout = e_cout;
    e.run  = e_run;
    e.dir  = e_dir;
    e.mx   = (e_bcd == limit);
    e.mn   = (e_bcd == 8'h00);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      me    = exp_q.pop_front();
      mname = nm_q.pop_front();
      chk(mname, "bcd",     bcd,           me.bcd);
      chk(mname, "cout",    8'(cout),      8'(me.cout));
      chk(mname, "running", 8'(running),   8'(me.run));
      chk(mname, "dir_eff", 8'(dir_eff),   8'(me.dir));
      chk(mname, "max",     8'(max),       8'(me.mx));
      chk(mname, "min",     8'(min),       8'(me.mn));
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    @(negedge clk);
    step("reset", 8'h00, 1'b0, 1'b1, 1'b1);
    step("reset", 8'h00, 1'b0, 1'b1, 1'b1);
    reset = 1'b1;
    tick  = 1'b1;

    for (int i = 1; i <= 59; i++) step("wrap_up", b2b(i), 1'b0, 1'b1, 1'b1);
    step("wrap_59_00", 8'h00, 1'b1, 1'b1, 1'b1);

    load = 1'b1; load_val = 8'h58;
    step("ld58", 8'h58, 1'b0, 1'b1, 1'b1);
    load = 1'b0; bounce = 1'b1;
    step("bnc_59", 8'h59, 1'b0, 1'b1, 1'b1);
    step("bnc_turn", 8'h58, 1'b1, 1'b1, 1'b0);
    for (int i = 57; i >= 0; i--) step("bnc_down", b2b(i), 1'b0, 1'b1, 1'b0);
    step("bnc_turn0", 8'h01, 1'b1, 1'b1, 1'b1);
    step("bnc_up", 8'h02, 1'b0, 1'b1, 1'b1);

    bounce = 1'b0; load = 1'b1; load_val = 8'h00;
    step("ld00", 8'h00, 1'b0, 1'b1, 1'b1);
    load = 1'b0; limit = 8'h89; dir = 1'b0;
    step("dn_wrap", 8'h89, 1'b1, 1'b1, 1'b0);
    step("dn", 8'h88, 1'b0, 1'b1, 1'b0);
    step("dn", 8'h87, 1'b0, 1'b1, 1'b0);

    dir = 1'b1; en_btn = 1'b1;
    step("btn_hi", 8'h88, 1'b0, 1'b1, 1'b1);
    en_btn = 1'b0;
    step("btn_fall", 8'h89, 1'b0, 1'b0, 1'b1);
    repeat (10) step("paused", 8'h89, 1'b0, 1'b0, 1'b1);
    en_btn = 1'b1;
    step("btn_hi2", 8'h89, 1'b0, 1'b0, 1'b1);
    en_btn = 1'b0;
    step("btn_fall2", 8'h89, 1'b0, 1'b1, 1'b1);
    step("resume_wrap", 8'h00, 1'b1, 1'b1, 1'b1);
    step("resume", 8'h01, 1'b0, 1'b1, 1'b1);
    step("resume", 8'h02, 1'b0, 1'b1, 1'b1);

    limit = 8'h59; load = 1'b1; load_val = 8'h42;
    step("ld42", 8'h42, 1'b0, 1'b1, 1'b1);
    load_val = 8'h7A;
    step("ld_bad_digit", 8'h59, 1'b0, 1'b1, 1'b1);
    load_val = 8'h65;
    step("ld_over_limit", 8'h59, 1'b0, 1'b1, 1'b1);
    load_val = 8'h13;
    step("ld_with_tick", 8'h13, 1'b0, 1'b1, 1'b1);
    load = 1'b0;
    step("after_ld", 8'h14, 1'b0, 1'b1, 1'b1);

    load = 1'b1; load_val = 8'h45;
    step("ld45", 8'h45, 1'b0, 1'b1, 1'b1);
    load = 1'b0; limit = 8'h30;
    step("lim_drop", 8'h30, 1'b0, 1'b1, 1'b1);
    step("lim_wrap", 8'h00, 1'b1, 1'b1, 1'b1);

    limit = 8'h00;
    step("lim0_up", 8'h00, 1'b0, 1'b1, 1'b1);
    dir = 1'b0;
    step("lim0_dn", 8'h00, 1'b0, 1'b1, 1'b0);

    limit = 8'h59; dir = 1'b1;
    step("pre_rst", 8'h01, 1'b0, 1'b1, 1'b1);
    en_btn = 1'b1;
    step("pre_rst", 8'h02, 1'b0, 1'b1, 1'b1);
    en_btn = 1'b0;
    step("stop", 8'h03, 1'b0, 1'b0, 1'b1);
    dir = 1'b0;
    step("stop_dir", 8'h03, 1'b0, 1'b0, 1'b0);
    reset = 1'b0; load = 1'b1; load_val = 8'h42;
    step("mid_reset", 8'h00, 1'b0, 1'b1, 1'b1);
    reset = 1'b1; load = 1'b0; dir = 1'b1;
    step("post_reset", 8'h01, 1'b0, 1'b1, 1'b1);

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d want=0 pending", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
